// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions: transfer types, response codes and the
// decode-error FSM state encoding.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Decode-error response: ERR1 is the wait cycle, ERR2 the final error cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } err_state_t;

endpackage

// File: rtl/ahbl_default_slave.sv
// Default slave for unmapped addresses: answers an accepted unmapped
// transfer with the two-cycle AHB ERROR response. Only instantiated when
// AHBL_SPLITTER_DECERR_EN is defined.
module ahbl_default_slave
    import ahbl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_hready,
    input  logic i_unmapped,
    output logic o_hready_resp,
    output logic o_hresp,
    output logic o_active
);

    err_state_t r_state;
    err_state_t w_state_next;

    // State register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and response outputs
    always_comb begin
        w_state_next  = r_state;
        o_hready_resp = 1'b1;
        o_hresp       = HRESP_OKAY;
        case (r_state)
            ST_IDLE: begin
                if (i_hready && i_unmapped) begin
                    w_state_next = ST_ERR1;
                end
            end
            ST_ERR1: begin
                o_hready_resp = 1'b0;
                o_hresp       = HRESP_ERROR;
                w_state_next  = ST_ERR2;
            end
            ST_ERR2: begin
                o_hready_resp = 1'b1;
                o_hresp       = HRESP_ERROR;
                // A new unmapped transfer accepted here restarts the error pair
                if (i_hready) begin
                    w_state_next = i_unmapped ? ST_ERR1 : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign o_active = (r_state != ST_IDLE);

endmodule

// File: rtl/onehot_mux.sv
// AND-OR multiplexer with a one-hot select; an all-zero select yields zero.
module onehot_mux #(
    parameter int N = 2,
    parameter int W = 32
) (
    input  logic [N-1:0]   i_sel,
    input  logic [N*W-1:0] i_data,
    output logic [W-1:0]   o_data
);

    logic [W-1:0] w_terms [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_term
            assign w_terms[gi] = i_data[gi*W +: W] & {W{i_sel[gi]}};
        end
    endgenerate

    // OR together the gated inputs
    always_comb begin
        o_data = '0;
        for (int i = 0; i < N; i++) begin
            o_data = o_data | w_terms[i];
        end
    end

endmodule

// File: rtl/ahbl_splitter.sv
// 1:N AHB-Lite splitter. Decodes the upstream address combinationally,
// steers HTRANS to the selected slave, broadcasts all other fields, and
// routes the response back through a registered data-phase select.
// Optional macro AHBL_SPLITTER_DECERR_EN: unmapped transfers receive a
// two-cycle ERROR response; without it they complete as OKAY with zero data.
module ahbl_splitter
    import ahbl_pkg::*;
#(
    parameter int                          N_PORTS   = 2,
    parameter int                          W_ADDR    = 32,
    parameter int                          W_DATA    = 32,
    parameter logic [N_PORTS*W_ADDR-1:0]   ADDR_MAP  = {N_PORTS{{W_ADDR{1'b0}}}},
    parameter logic [N_PORTS*W_ADDR-1:0]   ADDR_MASK = {N_PORTS{{W_ADDR{1'b0}}}}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          src_hready,
    output logic                          src_hready_resp,
    output logic                          src_hresp,
    input  logic [W_ADDR-1:0]             src_haddr,
    input  logic                          src_hwrite,
    input  logic [1:0]                    src_htrans,
    input  logic [2:0]                    src_hsize,
    input  logic [2:0]                    src_hburst,
    input  logic [3:0]                    src_hprot,
    input  logic                          src_hmastlock,
    input  logic [W_DATA-1:0]             src_hwdata,
    output logic [W_DATA-1:0]             src_hrdata,
    input  logic                          src_hexcl,
    input  logic [7:0]                    src_hmaster,
    output logic                          src_hexokay,
    output logic [N_PORTS-1:0]            dst_hready,
    input  logic [N_PORTS-1:0]            dst_hready_resp,
    input  logic [N_PORTS-1:0]            dst_hresp,
    output logic [N_PORTS*W_ADDR-1:0]     dst_haddr,
    output logic [N_PORTS-1:0]            dst_hwrite,
    output logic [N_PORTS*2-1:0]          dst_htrans,
    output logic [N_PORTS*3-1:0]          dst_hsize,
    output logic [N_PORTS*3-1:0]          dst_hburst,
    output logic [N_PORTS*4-1:0]          dst_hprot,
    output logic [N_PORTS-1:0]            dst_hmastlock,
    output logic [N_PORTS*W_DATA-1:0]     dst_hwdata,
    input  logic [N_PORTS*W_DATA-1:0]     dst_hrdata,
    output logic [N_PORTS-1:0]            dst_hexcl,
    output logic [N_PORTS*8-1:0]          dst_hmaster,
    input  logic [N_PORTS-1:0]            dst_hexokay,
    output logic [N_PORTS-1:0]            slave_sel_d
);

    // Response bundle per slave: {hready_resp, hresp, hexokay, hrdata}
    localparam int RW = W_DATA + 3;

    logic [N_PORTS-1:0]    w_hit;
    logic [N_PORTS-1:0]    w_hit_pri;
    logic [N_PORTS-1:0]    w_sel_a;
    logic [N_PORTS-1:0]    r_slave_sel_d;
    logic [N_PORTS*RW-1:0] w_resp_bus;
    logic [RW-1:0]         w_resp_sel;

    genvar gi;

    // Per-port address match and per-port response packing
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_port
            assign w_hit[gi] = ((src_haddr & ADDR_MASK[gi*W_ADDR +: W_ADDR])
                                == ADDR_MAP[gi*W_ADDR +: W_ADDR]);
            assign dst_htrans[gi*2 +: 2] = w_sel_a[gi] ? src_htrans : HTRANS_IDLE;
            assign w_resp_bus[gi*RW +: RW] = {dst_hready_resp[gi], dst_hresp[gi],
                                              dst_hexokay[gi],
                                              dst_hrdata[gi*W_DATA +: W_DATA]};
        end
    endgenerate

    // Overlapping regions resolve to the lowest-numbered port
    always_comb begin
        w_hit_pri = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_hit_pri    = '0;
                w_hit_pri[i] = 1'b1;
            end
        end
    end

    // IDLE and BUSY never select a slave
    assign w_sel_a = w_hit_pri & {N_PORTS{src_htrans[1]}};

    // Address-phase fields go to every slave; only HTRANS is steered
    assign dst_hready    = {N_PORTS{src_hready}};
    assign dst_haddr     = {N_PORTS{src_haddr}};
    assign dst_hwrite    = {N_PORTS{src_hwrite}};
    assign dst_hsize     = {N_PORTS{src_hsize}};
    assign dst_hburst    = {N_PORTS{src_hburst}};
    assign dst_hprot     = {N_PORTS{src_hprot}};
    assign dst_hmastlock = {N_PORTS{src_hmastlock}};
    assign dst_hwdata    = {N_PORTS{src_hwdata}};
    assign dst_hexcl     = {N_PORTS{src_hexcl}};
    assign dst_hmaster   = {N_PORTS{src_hmaster}};

    // Data-phase select advances only when the bus accepts the address phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slave_sel_d <= '0;
        end else if (src_hready) begin
            r_slave_sel_d <= w_sel_a;
        end
    end

    assign slave_sel_d = r_slave_sel_d;

    onehot_mux #(
        .N (N_PORTS),
        .W (RW)
    ) u_resp_mux (
        .i_sel  (r_slave_sel_d),
        .i_data (w_resp_bus),
        .o_data (w_resp_sel)
    );

`ifdef AHBL_SPLITTER_DECERR_EN
    logic w_unmapped;
    logic w_err_hready_resp;
    logic w_err_hresp;
    logic w_err_active;

    assign w_unmapped = src_htrans[1] & ~(|w_hit);

    ahbl_default_slave u_default_slave (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_hready      (src_hready),
        .i_unmapped    (w_unmapped),
        .o_hready_resp (w_err_hready_resp),
        .o_hresp       (w_err_hresp),
        .o_active      (w_err_active)
    );
`endif

    // Upstream response: selected slave, else an idle OKAY; an error in progress overrides
    always_comb begin
        src_hready_resp = 1'b1;
        src_hresp       = HRESP_OKAY;
        src_hexokay     = 1'b0;
        src_hrdata      = '0;
        if (|r_slave_sel_d) begin
            {src_hready_resp, src_hresp, src_hexokay, src_hrdata} = w_resp_sel;
        end
`ifdef AHBL_SPLITTER_DECERR_EN
        if (w_err_active) begin
            src_hready_resp = w_err_hready_resp;
            src_hresp       = w_err_hresp;
            src_hexokay     = 1'b0;
            src_hrdata      = '0;
        end
`endif
    end

endmodule

// File: doc/ahbl_splitter.md
# ahbl_splitter

1:N AHB-Lite splitter: one upstream master port fans out to N downstream slave ports by address decode. It is the mirror of the N:1 arbiter: masters feed arbiters, arbiters feed a splitter, and the splitter feeds the slaves. It adds zero address-phase latency. It registers the data-phase slave select to route responses. It also drives the per-slave data-phase select back to the arbiters and carries the exclusive-access signals in both directions.

## Interface

Parameters:
- N_PORTS, 2, number of downstream slave ports
- W_ADDR, 32, address width
- W_DATA, 32, data width
- ADDR_MAP, {N_PORTS{W_ADDR'h0}}, concatenated base address per port; port 0 in the LSBs
- ADDR_MASK, {N_PORTS{W_ADDR'h0}}, concatenated decode mask per port

Ports (clock and reset first):
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- src_hready  in  1  upstream bus HREADY
- src_hready_resp  out  1  HREADYOUT to upstream
- src_hresp  out  1  HRESP to upstream
- src_haddr  in  W_ADDR  upstream address
- src_hwrite  in  1  upstream write flag
- src_htrans  in  2  upstream transfer type
- src_hsize  in  3  upstream transfer size
- src_hburst  in  3  upstream burst type
- src_hprot  in  4  upstream protection
- src_hmastlock  in  1  upstream lock
- src_hwdata  in  W_DATA  upstream write data
- src_hrdata  out  W_DATA  read data to upstream
- src_hexcl  in  1  exclusive-access flag
- src_hmaster  in  8  master ID
- src_hexokay  out  1  exclusive-access OK
- dst_hready  out  N_PORTS  bus HREADY to each slave
- dst_hready_resp  in  N_PORTS  HREADYOUT from each slave
- dst_hresp  in  N_PORTS  HRESP from each slave
- dst_haddr / dst_hwrite / dst_hsize / dst_hburst / dst_hprot / dst_hmastlock / dst_hwdata / dst_hexcl / dst_hmaster  out  N_PORTS× field width  broadcast copies of the upstream fields
- dst_htrans  out  N_PORTS*2  per-slave transfer type
- dst_hrdata  in  N_PORTS*W_DATA  read data from each slave
- dst_hexokay  in  N_PORTS  exclusive-access OK from each slave
- slave_sel_d  out  N_PORTS  one-hot registered data-phase select; zero when no slave is in data phase

## Operation

- Decode: port i hits when (src_haddr & ADDR_MASK[i]) == ADDR_MAP[i].
  - If several ports hit, the lowest index wins; the result is a one-hot vector, sel_a.
  - A hit is qualified by src_htrans[1]; IDLE and BUSY select nothing.
- Address phase:
  - dst_htrans[i] = src_htrans when sel_a[i], else IDLE (2'b00).
  - All other address-phase fields, dst_hwdata and dst_hready (= src_hready) go to every port unchanged.
- Data-phase register: slave_sel_d loads sel_a when src_hready=1 and holds otherwise.
- Response mux, when slave_sel_d ≠ 0: src_hready_resp, src_hresp, src_hrdata and src_hexokay come from the selected slave.
- Response when slave_sel_d = 0 and no error is in progress: src_hready_resp=1, src_hresp=0, src_hrdata=0, src_hexokay=0.
- Unmapped transfer: an active transfer with no hit is handled by the default-slave behaviour (see Configuration).

## Timing

- Reset values:
  - slave_sel_d=0
  - error FSM in IDLE
  - src_hready_resp=1, src_hresp=0, src_hrdata=0, src_hexokay=0
  - all dst_htrans=IDLE
- Latency:
  - Decode and address outputs are combinational in the same cycle.
  - Responses are combinational from the slave, selected by the registered slave_sel_d.
- Wait states: while src_hready=0, slave_sel_d and the FSM state hold; address changes are ignored.
- Back-to-back transfers: when a data phase to port A ends in the same cycle as an address phase to port B (src_hready=1), slave_sel_d switches to B on the next edge.
- Error FSM states: IDLE → ERR1 → ERR2.
  - IDLE → ERR1 on src_hready & src_htrans[1] & no hit.
  - ERR1 drives hready_resp=0, hresp=1; always → ERR2.
  - ERR2 drives hready_resp=1, hresp=1. Next state is ERR1 if another unmapped transfer is accepted, else IDLE. A mapped transfer accepted in ERR2 loads slave_sel_d normally.
- Reset asserted mid-transfer: all state returns to the reset values immediately (asynchronous).

## Configuration

- AHBL_SPLITTER_DECERR_EN defined: unmapped active transfers get the two-cycle ERROR response described above.
- AHBL_SPLITTER_DECERR_EN undefined:
  - The FSM is absent.
  - Unmapped transfers complete in one cycle with OKAY and hrdata=0.
  - Writes to unmapped addresses are dropped.

## Structure

- Shared package ahbl_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ (2'b00/01/10/11)
  - HRESP_OKAY/ERROR
  - the error-FSM state encoding
- Sub-module ahbl_default_slave contains the error FSM; it is instantiated only under AHBL_SPLITTER_DECERR_EN.
- Response muxing reuses the existing onehot_mux, selected by slave_sel_d.

## Test plan

All scenarios use N_PORTS=2, ADDR_MAP={32'h4000_0000, 32'h0000_0000}, ADDR_MASK={32'hF000_0000, 32'hF000_0000}.

- Single read: NONSEQ read to 32'h4000_0010 → dst_htrans[3:2]=2'b10, dst_htrans[1:0]=IDLE; next cycle slave_sel_d=2'b10; slave 1 returns 32'hDEAD_BEEF → src_hrdata=32'hDEAD_BEEF.
- Wait states: port 0 holds dst_hready_resp[0]=0 for 3 cycles → src_hready_resp=0 for 3 cycles; slave_sel_d stays 2'b01 throughout.
- Back-to-back: write to 32'h0000_0004, then read from 32'h4000_0000 the next cycle → slave_sel_d goes 01 then 10; port 0 sees dst_hwdata during the second cycle.
- Unmapped transfer to 32'h8000_0000:
  - With the macro: hready_resp/hresp = 0/1, then 1/1, then back to 1/0.
  - Without the macro: single cycle with hready_resp=1, hresp=0, hrdata=0.
- Exclusive access: hexcl=1, hmaster=8'h01 to port 1; dst_hexokay[1]=1 → src_hexokay=1 in the data phase; IDLE cycles → src_hexokay=0.
- Reset: assert rst_n=0 during the ERR1 cycle → outputs return to the reset values at once; the first post-reset transfer decodes normally.
